jpeg_bitbuffer_ctrl: RTL and testbench
======================================

Name: jpeg_bitbuffer_ctrl

Overview:
- Entropy-segment input controller between the byte stream source and jpeg_bitbuffer.
- Removes 0xFF00 byte stuffing and drops 0xFF fill bytes.
- Detects RSTn and EOI markers. On those markers it drives the bitbuffer's last/drain and img_start (flush) inputs, so the Huffman decoder sees only scan data and restarts on a byte-aligned boundary.
- Produces the restart pulse that clears the DC predictors.

Parameters:
CHECK_RST_SEQ, 1, 1 = flag err_o when an RSTn index differs from the expected modulo-8 sequence; 0 = accept any RSTn.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
img_start_i  in  1  start of new image scan; synchronous pulse
inport_valid_i  in  1  scan byte valid
inport_data_i  in  8  scan byte
inport_last_i  in  1  final byte of the input stream
inport_accept_o  out  1  byte consumed this cycle
bb_valid_o  out  1  to bitbuffer inport_valid_i
bb_data_o  out  8  to bitbuffer inport_data_i
bb_last_o  out  1  to bitbuffer inport_last_i; 1-cycle pulse
bb_ready_i  in  1  from bitbuffer ready_o
bb_flush_o  out  1  to bitbuffer img_start_i; 1-cycle pulse
intv_done_i  in  1  decoder has consumed all MCUs of the current restart interval; pulse
restart_o  out  1  1-cycle pulse: reset DC predictors
marker_valid_o  out  1  1-cycle pulse: marker byte detected
marker_o  out  8  marker code (second byte); held until the next marker
err_o  out  1  sticky error flag; cleared by img_start_i

Behaviour:
- Reset (rst_ni low, asynchronous):
  - State IDLE, rst_seq_q = 0.
  - marker_o = 0x00.
  - All 1-bit outputs are 0.
- img_start_i: highest priority.
  - Next state PASS; rst_seq_q, err_o and marker_o are cleared.
  - bb_flush_o = img_start_i, combinationally in the same cycle.
  - The byte presented that cycle is not accepted.
- States: IDLE, PASS, FF_SEEN, WAIT_DRAIN, FLUSH, DONE.
- IDLE / DONE:
  - inport_accept_o = 0; leave only on img_start_i.
  - intv_done_i is ignored.
- PASS: inport_accept_o = bb_ready_i. A byte is taken when inport_valid_i && bb_ready_i, with zero latency. Per byte taken:
  - Byte != 0xFF: bb_valid_o = 1, bb_data_o = byte (combinational).
  - Byte == 0xFF: consumed, not forwarded; go to FF_SEEN.
  - inport_last_i on a forwarded byte: bb_last_o pulses the same cycle; go to DONE.
  - inport_last_i on a 0xFF byte: bb_last_o pulses, err_o set; go to DONE.
- FF_SEEN: inport_accept_o = bb_ready_i. On the next byte taken:
  - 0x00: bb_valid_o = 1, bb_data_o = 0xFF; go to PASS.
  - 0xFF: fill byte, consumed, not forwarded; stay in FF_SEEN.
  - 0xD0–0xD7 (RSTn):
    - Consumed; marker_valid_o pulses, marker_o = byte, bb_last_o pulses.
    - If CHECK_RST_SEQ and byte[2:0] != rst_seq_q, err_o is set.
    - Go to WAIT_DRAIN.
  - 0xD9 (EOI): consumed; marker_valid_o, bb_last_o pulse; go to DONE.
  - Any other byte: consumed; marker_valid_o pulses, err_o set, bb_last_o pulses; go to DONE.
  - inport_last_i together with 0x00: forward 0xFF, pulse bb_last_o, go to DONE.
- WAIT_DRAIN:
  - inport_accept_o = 0; the bitbuffer is in drain mode and serves the residual bits.
  - On intv_done_i, go to FLUSH.
- FLUSH (exactly 1 cycle):
  - bb_flush_o = 1 and restart_o = 1.
  - Discards the padding bits and clears the bitbuffer drain flag.
  - rst_seq_q increments with wrap 7 -> 0.
  - Next state PASS.
- Output invariants:
  - bb_valid_o is never asserted unless the byte is actually taken; no speculative valid.
  - bb_valid_o and bb_flush_o are never high together.
- Throughput: one byte per cycle in PASS while bb_ready_i = 1. Each stuffed pair costs one extra cycle.
- Simultaneous events:
  - img_start_i overrides intv_done_i, inport_last_i and any marker detection in the same cycle.
  - intv_done_i arriving in the same cycle a state enters WAIT_DRAIN is not seen; only intv_done_i sampled while in WAIT_DRAIN counts.

Decomposition:
- Package jpeg_ctrl_pkg:
  - State enum ctrl_state_t (3 bits).
  - Constants MARKER_PREFIX = 8'hFF, STUFF = 8'h00, RST0 = 8'hD0, RST7 = 8'hD7, EOI = 8'hD9.
- No sub-module. The marker classifier is a small combinational function in the package (is_rst, is_eoi).

Test Plan:
- Reset, then img_start; bytes 12 34 FF 00 56 with bb_ready = 1 -> bb_data 12 34 FF 56 on 4 cycles. The FF cycle has bb_valid = 0 and inport_accept = 1.
- Bytes AB FF FF FF 00 -> forwarded AB, FF. Both fill 0xFF bytes are dropped; err_o = 0.
- Bytes 11 FF D0 22 with intv_done pulsed 5 cycles later:
  - bb_last pulses with D0; marker_o = D0.
  - 22 is not accepted until FLUSH.
  - bb_flush and restart pulse 1 cycle after intv_done; 22 is forwarded on the next cycle.
- Sequence FF D0 … FF D2 with CHECK_RST_SEQ = 1 -> err_o rises on D2 (expected D1) and stays high until img_start_i.
- Bytes 33 FF D9 -> bb_last pulses, state DONE, inport_accept = 0; later bytes are ignored until img_start.
- bb_ready low for 3 cycles mid-stream, then rst_ni asserted during WAIT_DRAIN:
  - No byte is lost or duplicated while bb_ready is low.
  - Reset forces all outputs 0 immediately (asynchronously), state IDLE.

Source files
------------

// File: rtl/jpeg_ctrl_pkg.sv
// Shared types and marker classification for the JPEG entropy-segment input controller.
package jpeg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PASS       = 3'd1,
    ST_FF_SEEN    = 3'd2,
    ST_WAIT_DRAIN = 3'd3,
    ST_FLUSH      = 3'd4,
    ST_DONE       = 3'd5
  } ctrl_state_t;

  localparam logic [7:0] MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] STUFF         = 8'h00;
  localparam logic [7:0] RST0          = 8'hD0;
  localparam logic [7:0] RST7          = 8'hD7;
  localparam logic [7:0] EOI           = 8'hD9;

  function automatic logic is_rst(input logic [7:0] code);
    return (code >= RST0) && (code <= RST7);
  endfunction

  function automatic logic is_eoi(input logic [7:0] code);
    return code == EOI;
  endfunction

endpackage

// File: rtl/jpeg_bitbuffer_ctrl.sv
// Unstuffs the scan byte stream, strips fill bytes and turns RSTn/EOI markers into
// bitbuffer drain/flush control plus the DC-predictor restart pulse.
module jpeg_bitbuffer_ctrl
  import jpeg_ctrl_pkg::*;
#(
  parameter bit CHECK_RST_SEQ = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       img_start_i,
  input  logic       inport_valid_i,
  input  logic [7:0] inport_data_i,
  input  logic       inport_last_i,
  output logic       inport_accept_o,
  output logic       bb_valid_o,
  output logic [7:0] bb_data_o,
  output logic       bb_last_o,
  input  logic       bb_ready_i,
  output logic       bb_flush_o,
  input  logic       intv_done_i,
  output logic       restart_o,
  output logic       marker_valid_o,
  output logic [7:0] marker_o,
  output logic       err_o
);

  ctrl_state_t state_q, state_d;
  logic [2:0]  rst_seq_q, rst_seq_d;
  logic        err_q, err_d;
  logic [7:0]  marker_q, marker_d;

  logic active;
  logic take;

  // A new scan start wins over everything, so it also blocks the byte on the bus.
  assign active = (state_q == ST_PASS) || (state_q == ST_FF_SEEN);
  assign take   = active && inport_valid_i && bb_ready_i && !img_start_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      rst_seq_q <= 3'd0;
      err_q     <= 1'b0;
      marker_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      rst_seq_q <= rst_seq_d;
      err_q     <= err_d;
      marker_q  <= marker_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rst_seq_d = rst_seq_q;
    err_d     = err_q;
    marker_d  = marker_q;
    if (img_start_i) begin
      state_d   = ST_PASS;
      rst_seq_d = 3'd0;
      err_d     = 1'b0;
      marker_d  = 8'h00;
    end else begin
      unique case (state_q)
        ST_PASS: begin
          if (take) begin
            if (inport_data_i == MARKER_PREFIX) begin
              state_d = inport_last_i ? ST_DONE : ST_FF_SEEN;
              if (inport_last_i) err_d = 1'b1;
            end else if (inport_last_i) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_FF_SEEN: begin
          if (take) begin
            if (inport_data_i == STUFF) begin
              state_d = inport_last_i ? ST_DONE : ST_PASS;
            end else if (inport_data_i == MARKER_PREFIX) begin
              // A stream ending on a fill byte leaves a truncated marker.
              if (inport_last_i) begin
                state_d = ST_DONE;
                err_d   = 1'b1;
              end
            end else begin
              marker_d = inport_data_i;
              if (is_rst(inport_data_i)) begin
                if (CHECK_RST_SEQ && (inport_data_i[2:0] != rst_seq_q)) err_d = 1'b1;
                state_d = inport_last_i ? ST_DONE : ST_WAIT_DRAIN;
              end else if (is_eoi(inport_data_i)) begin
                state_d = ST_DONE;
              end else begin
                err_d   = 1'b1;
                state_d = ST_DONE;
              end
            end
          end
        end
        ST_WAIT_DRAIN: begin
          if (intv_done_i) state_d = ST_FLUSH;
        end
        ST_FLUSH: begin
          state_d   = ST_PASS;
          rst_seq_d = rst_seq_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    inport_accept_o = active && bb_ready_i && !img_start_i;
    bb_valid_o      = 1'b0;
    bb_data_o       = 8'h00;
    bb_last_o       = 1'b0;
    bb_flush_o      = img_start_i || (state_q == ST_FLUSH);
    restart_o       = !img_start_i && (state_q == ST_FLUSH);
    marker_valid_o  = 1'b0;
    marker_o        = marker_q;
    err_o           = err_q;
    if (take) begin
      if (state_q == ST_PASS) begin
        bb_last_o = inport_last_i;
        if (inport_data_i != MARKER_PREFIX) begin
          bb_valid_o = 1'b1;
          bb_data_o  = inport_data_i;
        end
      end else begin
        if (inport_data_i == STUFF) begin
          bb_valid_o = 1'b1;
          bb_data_o  = MARKER_PREFIX;
          bb_last_o  = inport_last_i;
        end else if (inport_data_i == MARKER_PREFIX) begin
          bb_last_o = inport_last_i;
        end else begin
          marker_valid_o = 1'b1;
          marker_o       = inport_data_i;
          bb_last_o      = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jpeg_bitbuffer_ctrl.sv
// Directed, table-driven bench for the JPEG bitbuffer input controller.
module tb_jpeg_bitbuffer_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       img_start_i;
  logic       inport_valid_i;
  logic [7:0] inport_data_i;
  logic       inport_last_i;
  logic       inport_accept_o;
  logic       bb_valid_o;
  logic [7:0] bb_data_o;
  logic       bb_last_o;
  logic       bb_ready_i;
  logic       bb_flush_o;
  logic       intv_done_i;
  logic       restart_o;
  logic       marker_valid_o;
  logic [7:0] marker_o;
  logic       err_o;

  int checks = 0;
  int failures = 0;

  jpeg_bitbuffer_ctrl #(.CHECK_RST_SEQ(1'b1)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .img_start_i    (img_start_i),
    .inport_valid_i (inport_valid_i),
    .inport_data_i  (inport_data_i),
    .inport_last_i  (inport_last_i),
    .inport_accept_o(inport_accept_o),
    .bb_valid_o     (bb_valid_o),
    .bb_data_o      (bb_data_o),
    .bb_last_o      (bb_last_o),
    .bb_ready_i     (bb_ready_i),
    .bb_flush_o     (bb_flush_o),
    .intv_done_i    (intv_done_i),
    .restart_o      (restart_o),
    .marker_valid_o (marker_valid_o),
    .marker_o       (marker_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  // One row per clock cycle; flags are {accept, bb_valid, bb_last, bb_flush, restart, marker_valid, err}.
  typedef struct {
    logic       st;
    logic       v;
    logic [7:0] d;
    logic       lst;
    logic       rdy;
    logic       idn;
    logic [6:0] flags;
    logic [7:0] bd;
    logic [7:0] mk;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic v, input logic [7:0] d, input logic lst,
                     input logic rdy, input logic idn, input logic [6:0] flags,
                     input logic [7:0] bd, input logic [7:0] mk);
    vec_t r;
    r.st = st; r.v = v; r.d = d; r.lst = lst; r.rdy = rdy; r.idn = idn;
    r.flags = flags; r.bd = bd; r.mk = mk;
    vecs.push_back(r);
  endtask

  task automatic applyStimulus(input logic st, input logic v, input logic [7:0] d,
                               input logic lst, input logic rdy, input logic idn);
    img_start_i    = st;
    inport_valid_i = v;
    inport_data_i  = d;
    inport_last_i  = lst;
    bb_ready_i     = rdy;
    intv_done_i    = idn;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] expFlags,
                             input logic [7:0] expData, input logic [7:0] expMarker);
    logic [6:0] actFlags;
    actFlags = {inport_accept_o, bb_valid_o, bb_last_o, bb_flush_o, restart_o, marker_valid_o, err_o};
    checks++;
    if ((actFlags !== expFlags) || (bb_data_o !== expData) || (marker_o !== expMarker)) begin
      failures++;
      $display("[TB] FAIL %s: got flags=%b data=%h marker=%h, expected flags=%b data=%h marker=%h",
               name, actFlags, bb_data_o, marker_o, expFlags, expData, expMarker);
    end
  endtask

  initial begin
    // Plain data with one stuffed pair
    add(1,1,8'h12,0,1,0, 7'b0001000, 8'h00, 8'h00);
    add(0,1,8'h12,0,1,0, 7'b1100000, 8'h12, 8'h00);
    add(0,1,8'h34,0,1,0, 7'b1100000, 8'h34, 8'h00);
    add(0,1,8'hFF,0,1,0, 7'b1000000, 8'h00, 8'h00);
    add(0,1,8'h00,0,1,0, 7'b1100000, 8'hFF, 8'h00);
    add(0,1,8'h56,0,1,0, 7'b1100000, 8'h56, 8'h00);
    // Fill bytes ahead of a stuffed pair
    add(0,1,8'hAB,0,1,0, 7'b1100000, 8'hAB, 8'h00);
    add(0,1,8'hFF,0,1,0, 7'b1000000, 8'h00, 8'h00);
    add(0,1,8'hFF,0,1,0, 7'b1000000, 8'h00, 8'h00);
    add(0,1,8'hFF,0,1,0, 7'b1000000, 8'h00, 8'h00);
    add(0,1,8'h00,0,1,0, 7'b1100000, 8'hFF, 8'h00);
    // RST0, drain, interval done, flush/restart, resume
    add(0,1,8'h11,0,1,0, 7'b1100000, 8'h11, 8'h00);
    add(0,1,8'hFF,0,1,0, 7'b1000000, 8'h00, 8'h00);
    add(0,1,8'hD0,0,1,0, 7'b1010010, 8'h00, 8'hD0);
    add(0,1,8'h22,0,1,0, 7'b0000000, 8'h00, 8'hD0);
    add(0,1,8'h22,0,1,0, 7'b0000000, 8'h00, 8'hD0);
    add(0,1,8'h22,0,1,0, 7'b0000000, 8'h00, 8'hD0);
    add(0,1,8'h22,0,1,0, 7'b0000000, 8'h00, 8'hD0);
    add(0,1,8'h22,0,1,1, 7'b0000000, 8'h00, 8'hD0);
    add(0,1,8'h22,0,1,0, 7'b0001100, 8'h00, 8'hD0);
    add(0,1,8'h22,0,1,0, 7'b1100000, 8'h22, 8'hD0);
    // Out-of-sequence RST2 (RST1 expected): sticky error
    add(0,1,8'hFF,0,1,0, 7'b1000000, 8'h00, 8'hD0);
    add(0,1,8'hD2,0,1,0, 7'b1010010, 8'h00, 8'hD2);
    add(0,0,8'h00,0,1,0, 7'b0000001, 8'h00, 8'hD2);
    add(0,0,8'h00,0,1,1, 7'b0000001, 8'h00, 8'hD2);
    add(0,0,8'h00,0,1,0, 7'b0001101, 8'h00, 8'hD2);
    add(0,0,8'h00,0,1,0, 7'b1000001, 8'h00, 8'hD2);
    // New scan clears error and marker; EOI ends the scan
    add(1,1,8'h44,0,1,0, 7'b0001001, 8'h00, 8'hD2);
    add(0,1,8'h33,0,1,0, 7'b1100000, 8'h33, 8'h00);
    add(0,1,8'hFF,0,1,0, 7'b1000000, 8'h00, 8'h00);
    add(0,1,8'hD9,0,1,0, 7'b1010010, 8'h00, 8'hD9);
    add(0,1,8'h55,0,1,0, 7'b0000000, 8'h00, 8'hD9);
    add(0,1,8'h66,0,1,1, 7'b0000000, 8'h00, 8'hD9);
    // Stream end on a plain byte, then on a stuffed pair
    add(1,0,8'h00,0,1,0, 7'b0001000, 8'h00, 8'hD9);
    add(0,1,8'h77,1,1,0, 7'b1110000, 8'h77, 8'h00);
    add(0,1,8'h88,0,1,0, 7'b0000000, 8'h00, 8'h00);
    add(1,0,8'h00,0,1,0, 7'b0001000, 8'h00, 8'h00);
    add(0,1,8'hFF,0,1,0, 7'b1000000, 8'h00, 8'h00);
    add(0,1,8'h00,1,1,0, 7'b1110000, 8'hFF, 8'h00);
    add(0,1,8'h99,0,1,0, 7'b0000000, 8'h00, 8'h00);
    // Backpressure for 3 cycles, then RST0 into drain
    add(1,0,8'h00,0,1,0, 7'b0001000, 8'h00, 8'h00);
    add(0,1,8'h01,0,1,0, 7'b1100000, 8'h01, 8'h00);
    add(0,1,8'h02,0,0,0, 7'b0000000, 8'h00, 8'h00);
    add(0,1,8'h02,0,0,0, 7'b0000000, 8'h00, 8'h00);
    add(0,1,8'h02,0,0,0, 7'b0000000, 8'h00, 8'h00);
    add(0,1,8'h02,0,1,0, 7'b1100000, 8'h02, 8'h00);
    add(0,1,8'h03,0,1,0, 7'b1100000, 8'h03, 8'h00);
    add(0,1,8'hFF,0,1,0, 7'b1000000, 8'h00, 8'h00);
    add(0,1,8'hD0,0,1,0, 7'b1010010, 8'h00, 8'hD0);
    add(0,1,8'h04,0,1,0, 7'b0000000, 8'h00, 8'hD0);

    rst_ni = 1'b1;
    applyStimulus(0,0,8'h00,0,0,0);
    #1 rst_ni = 1'b0;
    #2 checkOutput("reset", 7'b0000000, 8'h00, 8'h00);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].st, vecs[i].v, vecs[i].d, vecs[i].lst, vecs[i].rdy, vecs[i].idn);
      @(negedge clk_i);
      checkOutput($sformatf("row%0d", i), vecs[i].flags, vecs[i].bd, vecs[i].mk);
      @(posedge clk_i);
      #1;
    end

    // Asynchronous reset while draining: outputs drop before any clock edge
    applyStimulus(0,1,8'h05,0,1,0);
    #2 rst_ni = 1'b0;
    #1 checkOutput("async_reset", 7'b0000000, 8'h00, 8'h00);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    applyStimulus(0,1,8'h06,0,1,1);
    @(negedge clk_i);
    checkOutput("idle_after_reset", 7'b0000000, 8'h00, 8'h00);
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    checkOutput("idle_ignores_intv_done", 7'b0000000, 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
